// File: rtl/pipeline_exec_ctrl.sv
// Execution/hazard controller for the 5-stage pipeline: sequences run, step, drain and done
// modes, and issues load-use / decode-branch stalls plus IF/ID flushes.
module pipeline_exec_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int NB_CNT       = 32
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_step_req,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_jump,
    input  logic              i_id_branch,
    input  logic [4:0]        i_ifid_rs,
    input  logic [4:0]        i_ifid_rt,
    input  logic              i_idex_memRead,
    input  logic              i_idex_regWrite,
    input  logic [4:0]        i_idex_dst,
    output logic              o_step,
    output logic              o_stall,
    output logic              o_flush,
    output logic              o_done,
    output logic [2:0]        o_state,
    output logic [NB_CNT-1:0] o_cycle_count
);

    localparam int DW = ($clog2(DRAIN_CYCLES + 1) < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [DW-1:0]     drain_reg, drain_next;
    logic [NB_CNT-1:0] count_reg;

    logic hz;
    logic step;
    logic stall;
    logic flush;
    logic acc;

    // Hazard detect and Mealy outputs; stall dominates so a jump on stale operands never flushes.
    always_comb begin
        hz = (i_idex_memRead | (i_id_branch & i_idex_regWrite))
           & (i_idex_dst != 5'd0)
           & ((i_idex_dst == i_ifid_rs) | (i_idex_dst == i_ifid_rt));
        step  = (state_reg == RUN) | (state_reg == STEP) | (state_reg == DRAIN);
        stall = (step & hz & (state_reg != DRAIN)) | (state_reg == DRAIN);
        flush = step & i_jump & ~stall;
        acc   = step & i_stop & ~stall;
    end

    always_comb begin
        state_next = state_reg;
        drain_next = drain_reg;
        case (state_reg)
            IDLE: begin
                if (i_run)
                    state_next = RUN;
                else if (i_step_req)
                    state_next = STEP;
            end
            RUN: begin
                if (acc) begin
                    state_next = DRAIN;
                    drain_next = DW'(DRAIN_CYCLES);
                end else if (i_pause) begin
                    state_next = IDLE;
                end
            end
            STEP: begin
                if (acc) begin
                    state_next = DRAIN;
                    drain_next = DW'(DRAIN_CYCLES);
                end else begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (drain_reg <= DW'(1)) begin
                    state_next = DONE;
                    drain_next = '0;
                end else begin
                    drain_next = drain_reg - DW'(1);
                end
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_reg <= IDLE;
            drain_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            drain_reg <= drain_next;
            if (step)
                count_reg <= count_reg + NB_CNT'(1);
        end
    end

    assign o_step        = step;
    assign o_stall       = stall;
    assign o_flush       = flush;
    assign o_done        = (state_reg == DONE);
    assign o_state       = state_reg;
    assign o_cycle_count = count_reg;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed bench for pipeline_exec_ctrl: halt/drain timing, reset mid-drain, single step,
// hazard stall/flush behaviour, simultaneous commands and counter wrap (NB_CNT=4 copy).
module tb_pipeline_exec_ctrl;

    logic        clk = 1'b0;
    logic        i_reset, i_run, i_step_req, i_pause, i_stop, i_jump, i_id_branch;
    logic [4:0]  i_ifid_rs, i_ifid_rt, i_idex_dst;
    logic        i_idex_memRead, i_idex_regWrite;

    logic        step, stall, flush, done;
    logic [2:0]  state;
    logic [31:0] count;
    logic        step4, stall4, flush4, done4;
    logic [2:0]  state4;
    logic [3:0]  count4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_exec_ctrl u_dut (
        .clk(clk), .i_reset(i_reset), .i_run(i_run), .i_step_req(i_step_req),
        .i_pause(i_pause), .i_stop(i_stop), .i_jump(i_jump), .i_id_branch(i_id_branch),
        .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt), .i_idex_memRead(i_idex_memRead),
        .i_idex_regWrite(i_idex_regWrite), .i_idex_dst(i_idex_dst),
        .o_step(step), .o_stall(stall), .o_flush(flush), .o_done(done),
        .o_state(state), .o_cycle_count(count)
    );

    pipeline_exec_ctrl #(.DRAIN_CYCLES(3), .NB_CNT(4)) u_dut4 (
        .clk(clk), .i_reset(i_reset), .i_run(i_run), .i_step_req(i_step_req),
        .i_pause(i_pause), .i_stop(i_stop), .i_jump(i_jump), .i_id_branch(i_id_branch),
        .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt), .i_idex_memRead(i_idex_memRead),
        .i_idex_regWrite(i_idex_regWrite), .i_idex_dst(i_idex_dst),
        .o_step(step4), .o_stall(stall4), .o_flush(flush4), .o_done(done4),
        .o_state(state4), .o_cycle_count(count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("  ok %s = %0h", tag, got);
        end
    endtask

    task automatic clear_inputs;
        i_run = 0; i_step_req = 0; i_pause = 0; i_stop = 0; i_jump = 0; i_id_branch = 0;
        i_ifid_rs = 0; i_ifid_rt = 0; i_idex_memRead = 0; i_idex_regWrite = 0; i_idex_dst = 0;
    endtask

    // Move to just after the next rising edge, inputs cleared for the new cycle.
    task automatic tick;
        @(posedge clk);
        #1;
        clear_inputs();
        i_reset = 0;
    endtask

    // Reset sampled at the end of "cycle 0"; returns inside cycle 1.
    task automatic do_reset;
        tick();
        i_reset = 1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        i_reset = 1;

        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_step",  32'(step),  32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_count", count,      32'd0);
        check("rst_state4", 32'({step4, stall4, flush4, done4, state4, count4}), 32'd0);

        // Run at cycle 2, HALT at cycle 10 (and again at 12, ignored in DRAIN)
        for (int cyc = 2; cyc <= 17; cyc++) begin
            tick();
            i_run  = (cyc == 2);
            i_stop = (cyc == 10 || cyc == 12);
            @(negedge clk);
            check($sformatf("halt_step_c%0d", cyc),  32'(step),  32'((cyc >= 3 && cyc <= 13)));
            check($sformatf("halt_stall_c%0d", cyc), 32'(stall), 32'((cyc >= 11 && cyc <= 13)));
            check($sformatf("halt_done_c%0d", cyc),  32'(done),  32'((cyc >= 14)));
        end
        check("halt_count", count, 32'd11);
        check("halt_state", 32'(state), 32'd4);
        tick();
        i_run = 1; i_step_req = 1;
        tick();
        @(negedge clk);
        check("done_absorb_state", 32'(state), 32'd4);
        check("done_absorb_count", count, 32'd11);

        // Reset asserted mid-DRAIN (cycle 12)
        do_reset();
        for (int cyc = 2; cyc <= 12; cyc++) begin
            tick();
            i_run   = (cyc == 2);
            i_stop  = (cyc == 10);
            i_reset = (cyc == 12);
            @(negedge clk);
        end
        check("middrain_state_c12", 32'(state), 32'd3);
        tick();
        @(negedge clk);
        check("middrain_rst_state", 32'(state), 32'd0);
        check("middrain_rst_count", count, 32'd0);
        check("middrain_rst_step", 32'(step), 32'd0);

        // Single step at cycles 5 and 9; request in cycle 6 ignored
        do_reset();
        for (int cyc = 2; cyc <= 11; cyc++) begin
            tick();
            i_step_req = (cyc == 5 || cyc == 6 || cyc == 9);
            @(negedge clk);
            check($sformatf("sstep_step_c%0d", cyc),  32'(step),  32'((cyc == 6 || cyc == 10)));
            check($sformatf("sstep_state_c%0d", cyc), 32'(state), (cyc == 6 || cyc == 10) ? 32'd2 : 32'd0);
        end
        check("sstep_count", count, 32'd2);

        // Hazards while running
        do_reset();
        tick(); i_run = 1;
        tick();
        i_idex_memRead = 1; i_idex_dst = 8; i_ifid_rt = 8;
        @(negedge clk);
        check("lu_stall", 32'(stall), 32'd1);
        check("lu_state", 32'(state), 32'd1);
        tick();
        @(negedge clk);
        check("lu_bubble_stall", 32'(stall), 32'd0);
        tick();
        i_idex_memRead = 1; i_idex_dst = 0; i_ifid_rt = 0; i_ifid_rs = 0;
        @(negedge clk);
        check("lu_r0_stall", 32'(stall), 32'd0);
        tick();
        i_idex_memRead = 1; i_idex_dst = 8; i_ifid_rs = 8; i_ifid_rt = 3;
        @(negedge clk);
        check("lu_rs_stall", 32'(stall), 32'd1);
        tick();
        i_id_branch = 1; i_idex_regWrite = 1; i_idex_dst = 3; i_ifid_rs = 3; i_jump = 1;
        @(negedge clk);
        check("br_hz_stall", 32'(stall), 32'd1);
        check("br_hz_flush", 32'(flush), 32'd0);
        tick();
        i_jump = 1;
        @(negedge clk);
        check("br_clear_flush", 32'(flush), 32'd1);
        check("br_clear_stall", 32'(stall), 32'd0);
        tick();
        i_idex_regWrite = 1; i_idex_dst = 3; i_ifid_rs = 3;
        @(negedge clk);
        check("alu_nobranch_stall", 32'(stall), 32'd0);
        tick();
        i_stop = 1; i_step_req = 1; i_idex_memRead = 1; i_idex_dst = 5; i_ifid_rt = 5;
        @(negedge clk);
        check("stop_hz_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        check("stop_hz_state", 32'(state), 32'd1);
        tick();
        i_pause = 1; i_stop = 1;
        @(negedge clk);
        tick();
        i_jump = 1;
        @(negedge clk);
        check("pause_stop_state", 32'(state), 32'd3);
        check("drain_stall", 32'(stall), 32'd1);
        check("drain_flush", 32'(flush), 32'd0);

        // run+step_req in IDLE gives RUN; pause returns to IDLE
        do_reset();
        tick(); i_run = 1; i_step_req = 1;
        tick();
        @(negedge clk);
        check("run_step_state", 32'(state), 32'd1);
        tick(); i_pause = 1;
        tick();
        @(negedge clk);
        check("pause_state", 32'(state), 32'd0);
        check("pause_step", 32'(step), 32'd0);

        // HALT accepted in STEP goes to DRAIN
        do_reset();
        tick(); i_step_req = 1;
        tick(); i_stop = 1;
        @(negedge clk);
        check("step_stop_state", 32'(state), 32'd2);
        tick();
        @(negedge clk);
        check("step_stop_drain", 32'(state), 32'd3);

        // 17 stepped cycles: 4-bit counter wraps to 1
        do_reset();
        tick(); i_run = 1;
        for (int n = 1; n <= 17; n++) begin
            tick();
            i_pause = (n == 17);
        end
        tick();
        @(negedge clk);
        check("wrap_count4", 32'(count4), 32'd1);
        check("wrap_count32", count, 32'd17);
        check("wrap_state", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
